// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator sequencer: key codes,
// operator and state encodings, and segment-driver display codes.
package calc_pkg;

  localparam int unsigned MAX_DIGITS = 6;
  localparam int          DISP_MAX   = 999999;
  localparam int          DISP_MIN   = -99999;

  localparam logic [4:0] KEY_0     = 5'h00;
  localparam logic [4:0] KEY_9     = 5'h09;
  localparam logic [4:0] KEY_PLUS  = 5'h0A;
  localparam logic [4:0] KEY_MINUS = 5'h0B;
  localparam logic [4:0] KEY_MUL   = 5'h0C;
  localparam logic [4:0] KEY_DIV   = 5'h0D;
  localparam logic [4:0] KEY_MOD   = 5'h0E;
  localparam logic [4:0] KEY_EQ    = 5'h0F;
  localparam logic [4:0] KEY_IDLE  = 5'h1F;

  localparam logic [31:0] FND_ERR   = 32'h00EE_0000;
  localparam logic [31:0] FND_PLUS  = 32'h0010_0000;
  localparam logic [31:0] FND_MINUS = 32'h0020_0000;
  localparam logic [31:0] FND_MUL   = 32'h0030_0000;
  localparam logic [31:0] FND_DIV   = 32'h0040_0000;
  localparam logic [31:0] FND_MOD   = 32'h0050_0000;

  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD} op_t;
  typedef enum logic [2:0] {ENTER_A, OP_SHOW, ENTER_B, EXEC, RESULT, ERROR} state_t;

  function automatic op_t key_to_op(logic [4:0] key);
    case (key)
      KEY_PLUS:  return OP_ADD;
      KEY_MINUS: return OP_SUB;
      KEY_MUL:   return OP_MUL;
      KEY_DIV:   return OP_DIV;
      KEY_MOD:   return OP_MOD;
      default:   return OP_NONE;
    endcase
  endfunction

  function automatic logic [31:0] op_to_fnd(op_t op);
    case (op)
      OP_ADD:  return FND_PLUS;
      OP_SUB:  return FND_MINUS;
      OP_MUL:  return FND_MUL;
      OP_DIV:  return FND_DIV;
      OP_MOD:  return FND_MOD;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad-in / display-out bundle between the calculator sequencer and its
// surroundings (keypad driver, segment driver).
interface calc_if;
  logic [4:0]  eBCD;
  logic        clr;
  logic [31:0] fnd_serial;
  logic        busy;
  logic        err;

  modport master (output eBCD, clr, input fnd_serial, busy, err);
  modport slave  (input eBCD, clr, output fnd_serial, busy, err);
endinterface

// File: rtl/calc_alu.sv
// Shared arithmetic unit: single-cycle add/sub/mul, 32-step restoring
// divider for div/mod with the sign fix folded into the final step.
module calc_alu
  import calc_pkg::*;
(
  input  logic               sw_clk,
  input  logic               rst,
  input  logic               start,
  input  op_t                op,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] result,
  output logic               err
);

  logic [5:0]         cnt;
  logic [31:0]        rem, quo, dvs;
  logic               neg_q, neg_r, is_mod;
  logic signed [63:0] prod;
  logic [31:0]        a_mag, b_mag, rem_next, quo_next;
  logic [32:0]        rem_shift, diff;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    prod      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    a_mag     = a[31] ? 32'(-a) : 32'(a);
    b_mag     = b[31] ? 32'(-b) : 32'(b);
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, dvs};
    rem_next  = diff[32] ? rem_shift[31:0] : diff[31:0];
    quo_next  = {quo[30:0], ~diff[32]};
  end

  assign busy = (cnt != 6'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_mod <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cnt != 6'd0) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          done   <= 1'b1;
          result <= is_mod ? (neg_r ? -rem_next : rem_next)
                           : (neg_q ? -quo_next : quo_next);
        end
      end else if (start) begin
        err <= 1'b0;
        case (op)
          OP_ADD: begin result <= a + b; done <= 1'b1; end
          OP_SUB: begin result <= a - b; done <= 1'b1; end
          OP_MUL: begin
            result <= prod[31:0];
            err    <= (prod[63:32] != {32{prod[31]}});
            done   <= 1'b1;
          end
          OP_DIV, OP_MOD: begin
            rem    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            neg_q  <= a[31] ^ b[31];
            neg_r  <= a[31];
            is_mod <= (op == OP_MOD);
            err    <= (b == 32'sd0);
            cnt    <= 6'd32;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: key edge detection, operand/operator entry FSM,
// ALU launch over start/done, and the registered display word.
module calc_controller
  import calc_pkg::*;
(
  input  logic sw_clk,
  input  logic rst,
  calc_if.slave bus
);

  state_t             state;
  op_t                op, chain, key_op;
  logic signed [31:0] a_reg, b_reg, fnd, digit, a_acc, b_acc, alu_result;
  logic [2:0]         cnt;
  logic [4:0]         key_prev;
  logic               busy_q, err_q, start, stale;
  logic               key_ev, is_digit, is_op, is_eq, can_add;
  logic               alu_busy, alu_done, alu_err;

  always_comb begin
    key_ev   = (bus.eBCD != KEY_IDLE) && (key_prev == KEY_IDLE);
    is_digit = key_ev && (bus.eBCD <= KEY_9);
    is_op    = key_ev && (bus.eBCD >= KEY_PLUS) && (bus.eBCD <= KEY_MOD);
    is_eq    = key_ev && (bus.eBCD == KEY_EQ);
    key_op   = key_to_op(bus.eBCD);
    digit    = {27'd0, bus.eBCD - KEY_0};
    a_acc    = a_reg * 32'sd10 + digit;
    b_acc    = b_reg * 32'sd10 + digit;
    can_add  = cnt < 3'(MAX_DIGITS);
  end

  calc_alu u_alu (
    .sw_clk (sw_clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a_reg),
    .b      (b_reg),
    .busy   (alu_busy),
    .done   (alu_done),
    .result (alu_result),
    .err    (alu_err)
  );

  // stale marks an ALU operation abandoned by clr; its done is swallowed and,
  // if a new operation was issued meanwhile (start ignored while busy), re-launched.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state    <= ENTER_A;
      op       <= OP_NONE;
      chain    <= OP_NONE;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      key_prev <= KEY_IDLE;
      fnd      <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      start    <= 1'b0;
      stale    <= 1'b0;
    end else begin
      key_prev <= bus.eBCD;
      start    <= 1'b0;
      if (alu_done) stale <= 1'b0;
      if (bus.clr) begin
        state  <= ENTER_A;
        op     <= OP_NONE;
        chain  <= OP_NONE;
        a_reg  <= '0;
        b_reg  <= '0;
        cnt    <= '0;
        fnd    <= '0;
        busy_q <= 1'b0;
        err_q  <= 1'b0;
        stale  <= (stale || state == EXEC || alu_busy) && !alu_done;
      end else begin
        case (state)
          ENTER_A, ENTER_B: begin
            if (is_digit && can_add) begin
              cnt <= cnt + 3'd1;
              if (state == ENTER_A) begin a_reg <= a_acc; fnd <= a_acc; end
              else                  begin b_reg <= b_acc; fnd <= b_acc; end
            end else if (is_op && state == ENTER_A) begin
              op    <= key_op;
              fnd   <= op_to_fnd(key_op);
              state <= OP_SHOW;
            end else if ((is_op || is_eq) && state == ENTER_B) begin
              chain  <= is_op ? key_op : OP_NONE;
              start  <= 1'b1;
              busy_q <= 1'b1;
              state  <= EXEC;
            end
          end
          OP_SHOW, RESULT: begin
            if (is_digit) begin
              cnt <= 3'd1;
              fnd <= digit;
              if (state == OP_SHOW) begin b_reg <= digit; state <= ENTER_B; end
              else                  begin a_reg <= digit; state <= ENTER_A; end
            end else if (is_op) begin
              op    <= key_op;
              fnd   <= op_to_fnd(key_op);
              state <= OP_SHOW;
            end
          end
          EXEC: begin
            if (alu_done && stale) begin
              start <= 1'b1;
            end else if (alu_done) begin
              busy_q <= 1'b0;
              if (alu_err || alu_result > DISP_MAX || alu_result < DISP_MIN) begin
                fnd   <= FND_ERR;
                err_q <= 1'b1;
                state <= ERROR;
              end else if (chain != OP_NONE) begin
                a_reg <= alu_result;
                op    <= chain;
                fnd   <= op_to_fnd(chain);
                state <= OP_SHOW;
              end else begin
                a_reg <= alu_result;
                fnd   <= alu_result;
                state <= RESULT;
              end
            end
          end
          ERROR:   ;
          default: state <= ENTER_A;
        endcase
      end
    end
  end

  assign bus.fnd_serial = fnd;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed and randomized key sequences against an arithmetic reference of
// the calculator's visible behaviour.
module tb_calc_controller;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  calc_if bus ();

  calc_controller dut (
    .sw_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] key, input int hold = 3);
    @(negedge clk);
    bus.eBCD = key;
    repeat (hold) @(negedge clk);
    bus.eBCD = KEY_IDLE;
    repeat (2) @(negedge clk);
  endtask

  // Presses '=' and counts cycles with busy high; bounded wait.
  task automatic press_eq(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    bus.eBCD = KEY_EQ;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    bus.eBCD = KEY_IDLE;
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic enter_num(input int value, input int hold);
    int digs[8];
    int n = 0;
    int v = value;
    do begin
      digs[n] = v % 10;
      v = v / 10;
      n++;
    end while (v > 0);
    for (int i = n - 1; i >= 0; i--) press(5'(digs[i]), hold);
  endtask

  // Reference: what the display should show after "a op b =".
  function automatic logic [31:0] model(input int opi, input longint a, input longint b,
                                        output logic e);
    longint r = 0;
    bit     bad = 0;
    case (opi)
      0: r = a + b;
      1: r = a - b;
      2: begin
        r = a * b;
        if (r > 64'sd2147483647 || r < -64'sd2147483648) bad = 1;
      end
      3: if (b == 0) bad = 1; else r = a / b;
      default: if (b == 0) bad = 1; else r = a % b;
    endcase
    if (bad || r > DISP_MAX || r < DISP_MIN) begin
      e = 1'b1;
      return FND_ERR;
    end
    e = 1'b0;
    return r[31:0];
  endfunction

  initial begin
    int          n;
    bit          moved;
    logic [31:0] exp_fnd;
    logic        exp_err;

    rst      = 1'b0;
    bus.eBCD = KEY_IDLE;
    bus.clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_fnd", bus.fnd_serial, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1 2 + 3 =
    press(5'd1); check("a_1", bus.fnd_serial, 32'd1);
    press(5'd2); check("a_12", bus.fnd_serial, 32'd12);
    press(KEY_PLUS); check("show_plus", bus.fnd_serial, FND_PLUS);
    press(5'd3); check("b_3", bus.fnd_serial, 32'd3);
    press_eq(n);
    check("add_busy_cycles", n, 32'd2);
    check("add_result", bus.fnd_serial, 32'd15);
    check("add_err", {31'd0, bus.err}, 32'd0);

    // 7 / 0 = -> Error
    do_clr();
    press(5'd7); press(KEY_DIV); press(5'd0);
    press_eq(n);
    check("div0_busy_long", {31'd0, (n >= 33 && n <= 34)}, 32'd1);
    check("div0_fnd", bus.fnd_serial, FND_ERR);
    check("div0_err", {31'd0, bus.err}, 32'd1);
    press(5'd5);
    check("err_sticky", bus.fnd_serial, FND_ERR);
    do_clr();
    check("clr_fnd", bus.fnd_serial, 32'd0);
    check("clr_err", {31'd0, bus.err}, 32'd0);

    // - 7 = from A=0, then % 3 =
    press(KEY_MINUS); press(5'd7);
    press_eq(n);
    check("neg7", bus.fnd_serial, 32'hFFFF_FFF9);
    press(KEY_MOD); press(5'd3);
    press_eq(n);
    check("mod_sign", bus.fnd_serial, 32'hFFFF_FFFF);

    // digit limit, then overflow of display range
    do_clr();
    for (int d = 1; d <= 7; d++) press(5'(d));
    check("digit_limit", bus.fnd_serial, 32'd123456);
    press(KEY_MUL); press(5'd9);
    press_eq(n);
    check("disp_ovf_fnd", bus.fnd_serial, FND_ERR);
    check("disp_ovf_err", {31'd0, bus.err}, 32'd1);

    // chain 2 + 3 * 4 =
    do_clr();
    press(5'd2); press(KEY_PLUS); press(5'd3); press(KEY_MUL);
    check("chain_show_mul", bus.fnd_serial, FND_MUL);
    check("chain_not_busy", {31'd0, bus.busy}, 32'd0);
    press(5'd4, 10);
    check("held_one_digit", bus.fnd_serial, 32'd4);
    press_eq(n);
    check("chain_result", bus.fnd_serial, 32'd20);

    // clr mid-divide: abort, no late update
    do_clr();
    press(5'd9); press(5'd9); press(KEY_DIV); press(5'd2);
    @(negedge clk); bus.eBCD = KEY_EQ;
    repeat (10) @(negedge clk);
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.eBCD = KEY_IDLE;
    check("abort_fnd", bus.fnd_serial, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    moved = 0;
    repeat (40) begin @(negedge clk); if (bus.fnd_serial !== 32'd0 || bus.busy) moved = 1; end
    check("abort_no_late", {31'd0, moved}, 32'd0);
    press(5'd9); press(5'd9); press(KEY_DIV); press(5'd2);
    press_eq(n);
    check("after_abort_div", bus.fnd_serial, 32'd49);

    // async reset mid-divide
    do_clr();
    press(5'd9); press(5'd9); press(KEY_DIV); press(5'd2);
    @(negedge clk); bus.eBCD = KEY_EQ;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_fnd", bus.fnd_serial, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    bus.eBCD = KEY_IDLE;
    @(negedge clk); rst = 1'b1;
    moved = 0;
    repeat (40) begin @(negedge clk); if (bus.fnd_serial !== 32'd0) moved = 1; end
    check("rst_no_late", {31'd0, moved}, 32'd0);

    // randomized a op b =
    for (int t = 0; t < 20; t++) begin
      int a, b, opi, hold;
      a    = int'($urandom_range(0, 999999));
      b    = int'($urandom_range(0, 9999));
      if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 9));
      opi  = int'($urandom_range(0, 4));
      hold = int'($urandom_range(1, 4));
      do_clr();
      enter_num(a, hold);
      check("rnd_a", bus.fnd_serial, 32'(a));
      press(5'(int'(KEY_PLUS) + opi), hold);
      enter_num(b, hold);
      check("rnd_b", bus.fnd_serial, 32'(b));
      press_eq(n);
      exp_fnd = model(opi, longint'(a), longint'(b), exp_err);
      check("rnd_result", bus.fnd_serial, exp_fnd);
      check("rnd_err", {31'd0, bus.err}, {31'd0, exp_err});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
